bitfusion_pe_acc: RTL

Parametrised, mode-configurable bit-fusion PE built from 2x2-bit bricks. It fuses N_BRICK bricks into 2-bit, 4-bit or 8-bit multiplies and sums the per-beat products. It applies a per-beat left shift for bit-serial temporal composition, then accumulates across a multi-beat group with saturation. It sits in the PE array between the operand broadcast buffers and the output collection network.

---
 rtl/bitfusion_pkg.sv | 75 +++++++
 rtl/bitfusion_brick.sv | 17 +
 rtl/bitfusion_fuse_tree.sv | 44 ++++
 rtl/bitfusion_pe_acc.sv | 133 +++++++++++++
 4 files changed

// File: rtl/bitfusion_pkg.sv
// Shared types, default widths, saturation limits and the brick-to-slice mapping
// for the bit-fusion PE.
package bitfusion_pkg;

   localparam int N_BRICK_DEF = 16;
   localparam int SUM_W_DEF   = 18;
   localparam int SHIFT_W_DEF = 4;
   localparam int ACC_W_DEF   = 32;

   localparam logic signed [ACC_W_DEF-1:0] ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
   localparam logic signed [ACC_W_DEF-1:0] ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

   typedef enum logic [1:0] {
      MODE_2B  = 2'b00,
      MODE_4B  = 2'b01,
      MODE_8B  = 2'b10,
      MODE_RSV = 2'b11
   } mode_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ACCUM = 1'b1
   } state_t;

   typedef struct packed {
      logic [4:0] a_lsb;
      logic [4:0] w_lsb;
      logic [3:0] shift;
      logic       a_top;
      logic       w_top;
   } brick_map_t;

   // Brick b pairs activation slice si with weight slice sj of one element and
   // weights the product by 2^(2(si+sj)); only an element's top slice is signed.
   function automatic brick_map_t brick_map(mode_t mode, int unsigned b);
      brick_map_t  m;
      int unsigned si;
      int unsigned sj;
      int unsigned base;
      m    = '0;
      si   = 0;
      sj   = 0;
      base = 0;
      case (mode)
         MODE_4B: begin
            base    = 4 * (b / 4);
            si      = b % 2;
            sj      = (b / 2) % 2;
            m.a_lsb = 5'(base + 2 * si);
            m.w_lsb = 5'(base + 2 * sj);
            m.shift = 4'(2 * (si + sj));
            m.a_top = (si == 1);
            m.w_top = (sj == 1);
         end
         MODE_8B: begin
            si      = b % 4;
            sj      = b / 4;
            m.a_lsb = 5'(2 * si);
            m.w_lsb = 5'(2 * sj);
            m.shift = 4'(2 * (si + sj));
            m.a_top = (si == 3);
            m.w_top = (sj == 3);
         end
         default: begin
            m.a_lsb = 5'(2 * b);
            m.w_lsb = 5'(2 * b);
            m.shift = 4'd0;
            m.a_top = 1'b1;
            m.w_top = 1'b1;
         end
      endcase
      return m;
   endfunction

endpackage

// File: rtl/bitfusion_brick.sv
// 2x2-bit multiplier brick; each operand slice is independently signed or unsigned.
module bitfusion_brick (
   input  logic              [1:0] a,
   input  logic              [1:0] w,
   input  logic                    a_signed,
   input  logic                    w_signed,
   output logic signed       [5:0] prod
);

   logic signed [2:0] a_x;
   logic signed [2:0] w_x;

   assign a_x  = {a_signed & a[1], a};
   assign w_x  = {w_signed & w[1], w};
   assign prod = 6'(a_x) * 6'(w_x);

endmodule

// File: rtl/bitfusion_fuse_tree.sv
// Combinational fusion tree: routes operand slices to the bricks for the current
// mode, weights each brick product and sums them into the per-beat result.
module bitfusion_fuse_tree
   import bitfusion_pkg::*;
#(
   parameter int N_BRICK = N_BRICK_DEF,
   parameter int SUM_W   = SUM_W_DEF
) (
   input  logic        [1:0]           mode,
   input  logic                        a_signed,
   input  logic                        w_signed,
   input  logic        [2*N_BRICK-1:0] activation,
   input  logic        [2*N_BRICK-1:0] weight,
   output logic signed [SUM_W-1:0]     beat_sum
);

   logic signed [SUM_W-1:0] term [N_BRICK];

   for (genvar b = 0; b < N_BRICK; b++) begin : g_brick
      brick_map_t        m;
      logic signed [5:0] prod;

      assign m = brick_map(mode_t'(mode), b);

      bitfusion_brick u_brick (
         .a        (activation[m.a_lsb +: 2]),
         .w        (weight[m.w_lsb +: 2]),
         .a_signed (a_signed & m.a_top),
         .w_signed (w_signed & m.w_top),
         .prod     (prod)
      );

      assign term[b] = SUM_W'(prod) <<< m.shift;
   end

   // NOTE: the sum starts from a default before the loop so always_comb never infers a latch.
   always_comb begin
      beat_sum = '0;
      for (int i = 0; i < N_BRICK; i++) begin
         beat_sum = beat_sum + term[i];
      end
   end

endmodule

// File: rtl/bitfusion_pe_acc.sv
// Bit-fusion PE: fused beat sum registered in stage 1, then shifted and
// accumulated with saturation across a multi-beat group in stage 2.
module bitfusion_pe_acc
   import bitfusion_pkg::*;
#(
   parameter int N_BRICK = N_BRICK_DEF,
   parameter int SUM_W   = SUM_W_DEF,
   parameter int SHIFT_W = SHIFT_W_DEF,
   parameter int ACC_W   = ACC_W_DEF
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic                        i_valid,
   input  logic                        i_last,
   input  logic                        i_clear,
   input  logic        [1:0]           i_mode,
   input  logic                        i_A_signed,
   input  logic                        i_W_signed,
   input  logic        [SHIFT_W-1:0]   i_shift,
   input  logic        [2*N_BRICK-1:0] i_activation,
   input  logic        [2*N_BRICK-1:0] i_weight,
   output logic                        o_valid,
   output logic signed [ACC_W-1:0]     o_acc,
   output logic                        o_ovf
);

   localparam int SHF_W  = SUM_W + 15;
   localparam int WIDE_W = ((ACC_W > SHF_W) ? ACC_W : SHF_W) + 2;
   localparam logic signed [WIDE_W-1:0] SAT_MAX = WIDE_W'({1'b0, {(ACC_W-1){1'b1}}});
   localparam logic signed [WIDE_W-1:0] SAT_MIN = ~SAT_MAX;

   logic signed [SUM_W-1:0]   beat_sum;
   logic                      s1_valid;
   logic                      s1_last;
   logic signed [SUM_W-1:0]   s1_sum;
   logic        [SHIFT_W-1:0] s1_shift;

   state_t                    state_q;
   state_t                    state_d;
   logic signed [ACC_W-1:0]   acc_q;
   logic                      ovf_q;

   logic                      take;
   logic signed [SHF_W-1:0]   shifted;
   logic signed [WIDE_W-1:0]  base_w;
   logic signed [WIDE_W-1:0]  sum_w;
   logic signed [ACC_W-1:0]   sat_acc;
   logic                      clip;
   logic                      ovf_now;

   bitfusion_fuse_tree #(
      .N_BRICK (N_BRICK),
      .SUM_W   (SUM_W)
   ) u_fuse (
      .mode       (i_mode),
      .a_signed   (i_A_signed),
      .w_signed   (i_W_signed),
      .activation (i_activation),
      .weight     (i_weight),
      .beat_sum   (beat_sum)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         s1_sum   <= '0;
         s1_shift <= '0;
      end else begin
         s1_valid <= i_valid;
         if (i_valid) begin
            s1_sum   <= beat_sum;
            s1_shift <= i_shift;
            s1_last  <= i_last;
         end
      end
   end

   // A clear in the same cycle wins over the stage-1 beat; a new beat still enters stage 1.
   assign take = s1_valid & ~i_clear;

   always_comb begin
      state_d = state_q;
      if (i_clear) begin
         state_d = ST_IDLE;
      end else if (s1_valid) begin
         state_d = s1_last ? ST_IDLE : ST_ACCUM;
      end
   end

   always_comb begin
      shifted = SHF_W'(s1_sum) <<< s1_shift;
      base_w  = (state_q == ST_ACCUM) ? WIDE_W'(acc_q) : '0;
      sum_w   = base_w + WIDE_W'(shifted);
      clip    = 1'b0;
      sat_acc = sum_w[ACC_W-1:0];
      if (sum_w > SAT_MAX) begin
         sat_acc = SAT_MAX[ACC_W-1:0];
         clip    = 1'b1;
      end else if (sum_w < SAT_MIN) begin
         sat_acc = SAT_MIN[ACC_W-1:0];
         clip    = 1'b1;
      end
      ovf_now = clip | ((state_q == ST_ACCUM) & ovf_q);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         o_valid <= 1'b0;
         o_acc   <= '0;
         o_ovf   <= 1'b0;
      end else begin
         state_q <= state_d;
         o_valid <= take & s1_last;
         if (i_clear) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
         end else if (take) begin
            acc_q <= sat_acc;
            ovf_q <= ovf_now;
         end
         if (take && s1_last) begin
            o_acc <= sat_acc;
            o_ovf <= ovf_now;
         end
      end
   end

endmodule
